// File: rtl/axi4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_pkg: burst-type codes, FSM state encodings and beat-size helper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic size_ok(input logic [2:0] size, input int unsigned data_width);
    return int'({29'd0, size}) == $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_slave_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_slave_mem_if: reduced AXI4 AW/W/B/AR/R bundle plus error flag.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  awvalid, awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid, wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid, bready;
  logic                  arvalid, arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid, rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  protocol_err;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wlast, bready,
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast, protocol_err
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wlast, bready,
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_burst_addr_gen: combinational next-word-index for FIXED/INCR/WRAP.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       len_i,
  input  logic [1:0]       burst_i,
  output logic [IDX_W-1:0] next_idx_o,
  output logic             wrap_ok_o
);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [IDX_W-1:0] mask;
  logic [IDX_W-1:0] incr;

  always_comb begin
    wrap_ok_o  = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    mask       = IDX_W'(len_i);
    incr       = idx_i + IDX_ONE;
    next_idx_o = incr;
    // Illegal WRAP lengths and the reserved burst code fall through to INCR.
    if (burst_i == AXI_BURST_FIXED) begin
      next_idx_o = idx_i;
    end else if ((burst_i == AXI_BURST_WRAP) && wrap_ok_o) begin
      next_idx_o = (idx_i & ~mask) | (incr & mask);
    end
  end
endmodule
`default_nettype wire

// File: rtl/axi4_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_slave_mem: word-array AXI4 subordinate, independent write/read FSMs.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_DEPTH  = 1024,
  parameter     INIT_FILE  = ""
) (
  input logic            clk,
  input logic            rst,
  axi4_slave_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] unused_awaddr, unused_araddr;
  assign unused_awaddr = bus.awaddr;
  assign unused_araddr = bus.araddr;

  wr_state_e             wst_q, wst_d;
  rd_state_e             rst_q, rst_d;
  logic [IDX_W-1:0]      widx_q, widx_d, ridx_q, ridx_d;
  logic [7:0]            wlen_q, wlen_d, rlen_q, rlen_d;
  logic [7:0]            wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]            wburst_q, wburst_d, rburst_q, rburst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  run_q;

  logic [IDX_W-1:0] aw_idx, ar_idx, w_next, r_next;
  logic             w_wrap_ok, r_wrap_ok;
  logic             awready, wready, arready, rvalid, rlast;
  logic             aw_fire, w_fire, ar_fire, r_fire;

  assign aw_idx = IDX_W'(bus.awaddr >> OFF_W);
  assign ar_idx = IDX_W'(bus.araddr >> OFF_W);

  axi4_burst_addr_gen #(.IDX_W(IDX_W)) u_wgen (
    .idx_i(widx_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_idx_o(w_next), .wrap_ok_o(w_wrap_ok)
  );

  axi4_burst_addr_gen #(.IDX_W(IDX_W)) u_rgen (
    .idx_i(ridx_q), .len_i(rlen_q), .burst_i(rburst_q),
    .next_idx_o(r_next), .wrap_ok_o(r_wrap_ok)
  );

  // run_q keeps the IDLE readies low for the whole reset window.
  assign awready = run_q && (wst_q == W_IDLE);
  assign wready  = (wst_q == W_DATA);
  assign arready = run_q && (rst_q == R_IDLE);
  assign rvalid  = (rst_q == R_DATA);
  assign rlast   = rvalid && (rcnt_q == rlen_q);

  assign aw_fire = bus.awvalid && awready;
  assign w_fire  = bus.wvalid && wready;
  assign ar_fire = bus.arvalid && arready;
  assign r_fire  = bus.rready && rvalid;

  assign bus.awready      = awready;
  assign bus.wready       = wready;
  assign bus.bvalid       = (wst_q == W_RESP);
  assign bus.arready      = arready;
  assign bus.rvalid       = rvalid;
  assign bus.rlast        = rlast;
  assign bus.rdata        = rdata_q;
  assign bus.protocol_err = err_q;

  always_comb begin
    wst_d    = wst_q;
    widx_d   = widx_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wburst_d = wburst_q;
    unique case (wst_q)
      W_IDLE: if (aw_fire) begin
        widx_d   = aw_idx;
        wlen_d   = bus.awlen;
        wburst_d = bus.awburst;
        wcnt_d   = 8'd0;
        wst_d    = W_DATA;
      end
      W_DATA: if (w_fire) begin
        widx_d = w_next;
        wcnt_d = wcnt_q + 8'd1;
        if (wcnt_q == wlen_q) wst_d = W_RESP;
      end
      W_RESP: if (bus.bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d    = rst_q;
    ridx_d   = ridx_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rburst_d = rburst_q;
    rdata_d  = rdata_q;
    unique case (rst_q)
      R_IDLE: if (ar_fire) begin
        ridx_d   = ar_idx;
        rlen_d   = bus.arlen;
        rburst_d = bus.arburst;
        rcnt_d   = 8'd0;
        rdata_d  = mem_q[ar_idx];
        rst_d    = R_DATA;
      end
      R_DATA: if (r_fire) begin
        if (rlast) begin
          rst_d = R_IDLE;
        end else begin
          ridx_d  = r_next;
          rcnt_d  = rcnt_q + 8'd1;
          rdata_d = mem_q[r_next];
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (aw_fire && (!size_ok(bus.awsize, DATA_WIDTH) || (bus.awburst == 2'b11))) err_d = 1'b1;
    if (ar_fire && (!size_ok(bus.arsize, DATA_WIDTH) || (bus.arburst == 2'b11))) err_d = 1'b1;
    if ((wst_q == W_DATA) && (wburst_q == AXI_BURST_WRAP) && !w_wrap_ok) err_d = 1'b1;
    if ((rst_q == R_DATA) && (rburst_q == AXI_BURST_WRAP) && !r_wrap_ok) err_d = 1'b1;
    if (w_fire && (bus.wlast != (wcnt_q == wlen_q))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      widx_q   <= '0;
      ridx_q   <= '0;
      wlen_q   <= 8'd0;
      rlen_q   <= 8'd0;
      wcnt_q   <= 8'd0;
      rcnt_q   <= 8'd0;
      wburst_q <= AXI_BURST_FIXED;
      rburst_q <= AXI_BURST_FIXED;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      widx_q   <= widx_d;
      ridx_q   <= ridx_d;
      wlen_q   <= wlen_d;
      rlen_q   <= rlen_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      wburst_q <= wburst_d;
      rburst_q <= rburst_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Non-blocking write makes a same-edge fetch of this word read-first.
  always_ff @(posedge clk) begin
    if (w_fire && !rst) mem_q[widx_q] <= bus.wdata;
  end
endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi4_slave_mem: directed bench for bursts, backpressure and errors.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi4_slave_mem;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] exp_d [0:15];

  axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus ();

  axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .MEM_DEPTH(1024), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All tasks are entered and left on a falling edge.
  task automatic send_addr(input bit rd, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
    int t;
    if (rd) begin
      bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd4; bus.arburst = burst;
    end else begin
      bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd4; bus.awburst = burst;
    end
    t = 0;
    while (((rd ? bus.arready : bus.awready) !== 1'b1) && t < 50) begin
      @(negedge clk); t++;
    end
    checks++;
    if ((rd ? bus.arready : bus.awready) !== 1'b1) begin
      failures++; $display("FAIL addr_accept rd=%0d: ready got %b want 1", rd, rd ? bus.arready : bus.awready);
    end
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [DW-1:0] base, input int wlast_at, input int bdelay,
                          input int abort_after);
    int t;
    send_addr(1'b0, addr, len, burst);
    checks++;
    if (bus.wready !== 1'b1) begin failures++; $display("FAIL wready_after_aw: got %b want 1", bus.wready); end
    for (int k = 0; k <= int'(len); k++) begin
      if (k == abort_after) return;
      bus.wvalid = 1'b1;
      bus.wdata  = base + DW'(k);
      bus.wlast  = (wlast_at < 0) ? (k == int'(len)) : (k == wlast_at);
      t = 0;
      while (bus.wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin checks++; failures++; $display("FAIL wready_timeout beat %0d: got 0 want 1", k); end
      @(posedge clk); @(negedge clk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    checks++;
    if (bus.bvalid !== 1'b1) begin failures++; $display("FAIL bvalid_after_last: got %b want 1", bus.bvalid); end
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      checks++;
      if (bus.bvalid !== 1'b1) begin failures++; $display("FAIL bvalid_hold %0d: got %b want 1", i, bus.bvalid); end
    end
    bus.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.bready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      failures++; $display("FAIL b_done: bvalid,awready got %b want 01", {bus.bvalid, bus.awready});
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit stall);
    int k, c;
    bit held, rdy;
    logic [DW-1:0] hd;
    logic hl;
    send_addr(1'b1, addr, len, burst);
    checks++;
    if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL rvalid_after_ar: got %b want 1", bus.rvalid); end
    k = 0; c = 0; held = 0; hd = '0; hl = 1'b0;
    while (k <= int'(len) && c < 200) begin
      rdy = !stall || (c % 4 == 0) || (c % 4 == 3);
      bus.rready = rdy;
      if (held) begin
        checks++;
        if (bus.rdata !== hd || bus.rlast !== hl) begin
          failures++; $display("FAIL r_stall_stable beat %0d: got %h/%b want %h/%b", k, bus.rdata, bus.rlast, hd, hl);
        end
      end
      if (bus.rvalid === 1'b1 && rdy) begin
        checks++;
        if (bus.rdata !== exp_d[k]) begin
          failures++; $display("FAIL rdata beat %0d: got %h want %h", k, bus.rdata, exp_d[k]);
        end
        checks++;
        if (bus.rlast !== (k == int'(len))) begin
          failures++; $display("FAIL rlast beat %0d: got %b want %b", k, bus.rlast, k == int'(len));
        end
        k++; held = 0;
      end else begin
        held = (bus.rvalid === 1'b1); hd = bus.rdata; hl = bus.rlast;
      end
      @(posedge clk); @(negedge clk); c++;
    end
    bus.rready = 1'b0;
    checks++;
    if (k != int'(len) + 1) begin failures++; $display("FAIL read_beats: got %0d want %0d", k, int'(len) + 1); end
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b10) begin
      failures++; $display("FAIL r_done: arready,rvalid got %b want 10", {bus.arready, bus.rvalid});
    end
  endtask

  task automatic check_mem(input int idx, input logic [DW-1:0] want);
    checks++;
    if (dut.mem_q[idx] !== want) begin
      failures++; $display("FAIL mem[%0h]: got %h want %h", idx, dut.mem_q[idx], want);
    end
  endtask

  task automatic check_err(input logic want);
    checks++;
    if (bus.protocol_err !== want) begin
      failures++; $display("FAIL protocol_err: got %b want %b", bus.protocol_err, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast, bus.protocol_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast, bus.protocol_err});
    end
    checks++;
    if (bus.rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      failures++; $display("FAIL ready_after_reset: got %b want 11", {bus.awready, bus.arready});
    end
  endtask

  task automatic test_incr();
    do_write(32'h1000, 8'd7, 2'b01, 128'hA0, -1, 0, -1);
    for (int k = 0; k < 8; k++) begin
      check_mem(12'h100 + k, 128'hA0 + DW'(k));
      exp_d[k] = 128'hA0 + DW'(k);
    end
    do_read(32'h1000, 8'd7, 2'b01, 1'b0);
    check_err(1'b0);
  endtask

  task automatic test_wrap();
    do_write(32'h1020, 8'd3, 2'b10, 128'hB0, -1, 0, -1);
    check_mem(12'h102, 128'hB0); check_mem(12'h103, 128'hB1);
    check_mem(12'h100, 128'hB2); check_mem(12'h101, 128'hB3);
    for (int k = 0; k < 4; k++) exp_d[k] = 128'hB0 + DW'(k);
    do_read(32'h1020, 8'd3, 2'b10, 1'b0);
    check_err(1'b0);
  endtask

  task automatic test_fixed();
    do_write(32'h2010, 8'd0, 2'b01, 128'h55, -1, 0, -1);
    do_write(32'h2000, 8'd3, 2'b00, 128'hC0, -1, 0, -1);
    check_mem(12'h200, 128'hC3);
    check_mem(12'h201, 128'h55);
    exp_d[0] = 128'hC3;
    do_read(32'h2000, 8'd0, 2'b01, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 8; k++) exp_d[k] = 128'hA0 + DW'(k);
    exp_d[0] = 128'hB2; exp_d[1] = 128'hB3; exp_d[2] = 128'hB0; exp_d[3] = 128'hB1;
    do_read(32'h1000, 8'd7, 2'b01, 1'b1);
    do_write(32'h3000, 8'd1, 2'b01, 128'hD0, -1, 3, -1);
    check_mem(12'h300, 128'hD0); check_mem(12'h301, 128'hD1);
    check_err(1'b0);
  endtask

  task automatic test_err_wlast();
    do_write(32'h4000, 8'd3, 2'b01, 128'hE0, 2, 0, -1);
    for (int k = 0; k < 4; k++) check_mem(12'h400 + k, 128'hE0 + DW'(k));
    check_err(1'b1);
    test_reset();
  endtask

  task automatic test_err_wrap();
    do_write(32'h5030, 8'd2, 2'b10, 128'hF0, -1, 0, -1);
    check_mem(12'h503, 128'hF0); check_mem(12'h504, 128'hF1); check_mem(12'h505, 128'hF2);
    check_err(1'b1);
    for (int k = 0; k < 3; k++) exp_d[k] = 128'hF0 + DW'(k);
    do_read(32'h5030, 8'd2, 2'b10, 1'b0);
    test_reset();
  endtask

  task automatic test_reset_mid();
    do_write(32'h6000, 8'd7, 2'b01, 128'h10, -1, 0, 3);
    test_reset();
    check_mem(12'h600, 128'h10); check_mem(12'h601, 128'h11); check_mem(12'h602, 128'h12);
    do_write(32'h7000, 8'd0, 2'b01, 128'h77, -1, 0, -1);
    check_mem(12'h700, 128'h77);
    check_err(1'b0);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wlast = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) exp_d[i] = '0;
    @(negedge clk);
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_backpressure();
    test_err_wlast();
    test_err_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
